lsu_bus_ctrl: RTL

- Load/store bus controller directly downstream of the execute unit.
- Consumes each execute-stage memory request (address, data, direction, access size) and converts it into a word-aligned bus transaction with byte enables.
- Stalls the pipeline while the transaction is outstanding, then aligns and sign/zero-extends load data for register writeback.
- Also detects misaligned accesses and bus timeouts.

---
 rtl/lsu_bus_ctrl_if.sv | 36 +++
 rtl/lsu_bus_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl_if
//   Word-oriented data bus between the load/store controller and memory.
//
//   Signals (named from the controller's point of view):
//     bus_req_o    request valid, held until bus_gnt_i
//     bus_we_o     1 = write, 0 = read
//     bus_addr_o   word address, bits [1:0] always 00
//     bus_wdata_o  lane-replicated store data
//     bus_be_o     byte enables
//     bus_gnt_i    request accepted this cycle
//     bus_rvalid_i read data valid
//     bus_rdata_i  read data (full word)
//
//   Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface lsu_bus_ctrl_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl
//   Load/store bus controller behind the execute stage. Turns one memory
//   request into a word-aligned bus transaction with byte enables, stalls the
//   pipeline while it is outstanding, and writes aligned, extended load data
//   back to the register file. Flags misaligned accesses and bus timeouts.
//
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     req_i         one-cycle request qualifier from execute
//     we_i          1 = store, 0 = load
//     addr_i        byte address
//     wdata_i       store data, LSB-justified
//     size_i        00 byte, 01 half, 10/11 word
//     unsigned_i    zero-extend load data when 1
//     rd_i          load destination register
//     flush_i       pipeline flush
//     bus           lsu_bus_ctrl_if.master data bus
//     hold_o        pipeline stall request
//     reg_we_o      load writeback strobe (one cycle)
//     reg_waddr_o   writeback register
//     reg_wdata_o   extended load data
//     misalign_o    one-cycle misaligned-access pulse
//     bus_err_o     one-cycle bus timeout pulse
// ---------------------------------------------------------------------------
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [4:0]            rd_i,
    input  logic                  flush_i,
    lsu_bus_ctrl_if.master        bus,
    output logic                  hold_o,
    output logic                  reg_we_o,
    output logic [4:0]            reg_waddr_o,
    output logic [31:0]           reg_wdata_o,
    output logic                  misalign_o,
    output logic                  bus_err_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t           state_q, state_d;

    logic             lat_we;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [1:0]       lat_size;
    logic             lat_unsigned;
    logic [4:0]       lat_rd;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             tmo_hit;

    logic             misalign_q, bus_err_q, reg_we_q;
    logic [4:0]       reg_waddr_q;
    logic [31:0]      reg_wdata_q;

    logic             aligned;
    logic             accept, misalign_det, timeout, wb_fire;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      shifted;
    logic [31:0]      load_ext;

    // Size 11 is treated as a word access.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        aligned = 1'b1;
        case (size_i)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_i[0];
            default: aligned = (addr_i[1:0] == 2'b00);
        endcase
    end

    assign cnt_inc = cnt_q + CNT_W'(1);
    // The counter value during a cycle is the number of cycles already spent
    // in REQ+RESP; the abort lands on the edge where it reaches TIMEOUT_CYC.
    assign tmo_hit = (cnt_inc == TMO_VAL);

    // Next-state and control strobes.
    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        accept       = 1'b0;
        misalign_det = 1'b0;
        timeout      = 1'b0;
        wb_fire      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i && !flush_i) begin
                    if (aligned) begin
                        accept  = 1'b1;
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        misalign_det = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.bus_gnt_i && lat_we) begin
                    state_d = IDLE;                 // store completes on grant
                end else if (!bus.bus_gnt_i && flush_i) begin
                    state_d = IDLE;                 // drop ungranted request
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else if (bus.bus_gnt_i) begin
                    // Grant beats a simultaneous flush; the load still runs
                    // to completion but its writeback is killed.
                    if (flush_i) kill_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (flush_i) kill_d = 1'b1;
                if (bus.bus_rvalid_i) begin
                    wb_fire = !kill_d && (lat_rd != 5'd0);
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            lat_rd       <= '0;
            kill_q       <= 1'b0;
            cnt_q        <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_waddr_q  <= '0;
            reg_wdata_q  <= '0;
        end else begin
            kill_q <= kill_d;
            if (accept) begin
                lat_we       <= we_i;
                lat_addr     <= addr_i;
                lat_wdata    <= wdata_i;
                lat_size     <= size_i;
                lat_unsigned <= unsigned_i;
                lat_rd       <= rd_i;
                cnt_q        <= '0;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_inc;
            end
            misalign_q  <= misalign_det;
            bus_err_q   <= timeout;
            reg_we_q    <= wb_fire;
            reg_waddr_q <= wb_fire ? lat_rd   : 5'd0;
            reg_wdata_q <= wb_fire ? load_ext : 32'd0;
        end
    end

    // Store lane placement and byte enables from the latched request.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = lat_wdata;
        case (lat_size)
            2'b00: begin
                lane_be    = 4'b0001 << lat_addr[1:0];
                lane_wdata = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << lat_addr[1:0];
                lane_wdata = {2{lat_wdata[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = lat_wdata;
            end
        endcase
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted  = bus.bus_rdata_i >> {lat_addr[1:0], 3'b000};
        load_ext = shifted;
        case (lat_size)
            2'b00:   load_ext = lat_unsigned ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = lat_unsigned ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Bus fields are zero outside REQ so nothing leaks while idle or waiting.
    assign bus.bus_req_o   = (state_q == REQ);
    assign bus.bus_we_o    = (state_q == REQ) && lat_we;
    assign bus.bus_addr_o  = (state_q == REQ) ? {lat_addr[31:2], 2'b00} : 32'd0;
    assign bus.bus_wdata_o = (state_q == REQ) ? lane_wdata : 32'd0;
    assign bus.bus_be_o    = (state_q == REQ) ? lane_be : 4'd0;

    assign hold_o      = (state_q != IDLE) || accept;
    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;
endmodule
